// File: rtl/hitchhike_mod_pkg.sv
// Shared definitions for the backscatter modulator: FSM states and default
// geometry of the shift square wave and symbol grid.
package hitchhike_mod_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } mod_state_t;

    localparam int DEF_HALF_PERIOD   = 2;
    localparam int DEF_SYMBOL_CYCLES = 8;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/shift_clock_gen.sv
// Frequency-shift square wave source: div_cnt counts HALF_PERIOD clocks,
// sq toggles on each wrap. clear forces both back to 0 synchronously.
module shift_clock_gen
    import hitchhike_mod_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic clock,
    input  logic clear,
    input  logic en,
    output logic sq
);

    localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [DIV_W-1:0] div_cnt;

    // Half-period divider; sq flips every HALF_PERIOD enabled clocks
    always_ff @(posedge clock) begin
        if (clear) begin
            div_cnt <= '0;
            sq      <= 1'b0;
        end else if (en) begin
            if (div_cnt == DIV_W'(HALF_PERIOD - 1)) begin
                div_cnt <= '0;
                sq      <= ~sq;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/backscatter_modulator.sv
// Backscatter tag modulator: turns the serial data bit stream into the RF
// switch drive, a square wave whose phase is set per symbol from data_in.
// Build option MOD_DIFF_EN selects differential phase encoding; without it
// the phase of each symbol is the data bit itself.
module backscatter_modulator
    import hitchhike_mod_pkg::*;
#(
    parameter int HALF_PERIOD   = DEF_HALF_PERIOD,
    parameter int SYMBOL_CYCLES = DEF_SYMBOL_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sending,
    input  logic             data_in,
    output logic             rf_ctrl,
    output logic             busy,
    output logic             bit_tick,
    output logic [CNT_W-1:0] symbol_total
);

    localparam int SYM_W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;

    // The symbol must hold a whole number of square-wave periods so the
    // wave is back at sq=0 on every boundary (phase continuity).
    if (HALF_PERIOD < 1) begin : g_bad_half_period
        $error("backscatter_modulator: HALF_PERIOD must be >= 1");
    end else if ((SYMBOL_CYCLES < 2) || ((SYMBOL_CYCLES % (2 * HALF_PERIOD)) != 0)) begin : g_bad_symbol_cycles
        $error("backscatter_modulator: SYMBOL_CYCLES must be a multiple of 2*HALF_PERIOD");
    end

    mod_state_t       state, state_nxt;
    logic             sending_d;
    logic             start;
    logic [SYM_W-1:0] sym_cnt;
    logic             sym_last;
    logic             phase;
    logic             sq;
    logic             enter_send;   // IDLE -> SEND this edge
    logic             next_sym;     // boundary that continues in SEND

    assign start    = sending & ~sending_d;
    assign sym_last = (sym_cnt == SYM_W'(SYMBOL_CYCLES - 1));

    // Burst envelope edge detector
    always_ff @(posedge clock) begin
        if (reset) sending_d <= 1'b0;
        else       sending_d <= sending;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state; a start seen outside IDLE is simply ignored
    always_comb begin
        state_nxt  = state;
        enter_send = 1'b0;
        next_sym   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SEND;
                    enter_send = 1'b1;
                end
            end
            SEND: begin
                if (!sending)      state_nxt = sym_last ? IDLE : DRAIN;
                else if (sym_last) next_sym  = 1'b1;
            end
            DRAIN: begin
                if (sym_last) begin
                    if (sending) begin
                        state_nxt = SEND;
                        next_sym  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Symbol grid: held at 0 while idle so a burst starts on a fresh symbol
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) sym_cnt <= '0;
        else if (sym_last)          sym_cnt <= '0;
        else                        sym_cnt <= sym_cnt + SYM_W'(1);
    end

    // Per-symbol phase; DRAIN keeps the phase of the symbol being finished
    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= 1'b0;
        end else if (enter_send) begin
            // Differential mode starts from phase 0, so 0 ^ bit0 == bit0
            phase <= data_in;
        end else if (next_sym) begin
`ifdef MOD_DIFF_EN
            phase <= phase ^ data_in;
`else
            phase <= data_in;
`endif
        end
    end

    // Sent-symbol counter, saturating at all-ones
    always_ff @(posedge clock) begin
        if (reset)                                symbol_total <= '0;
        else if (bit_tick && symbol_total != '1)  symbol_total <= symbol_total + CNT_W'(1);
    end

    // Square wave is cleared while idle so every burst begins at sq=0
    shift_clock_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_shift_clock_gen (
        .clock(clock),
        .clear(reset || state == IDLE),
        .en   (state != IDLE),
        .sq   (sq)
    );

    // Outputs depend only on registered state, never directly on inputs
    assign busy     = (state != IDLE);
    assign bit_tick = (state == SEND) && (sym_cnt == '0);
    assign rf_ctrl  = busy & (sq ^ phase);

endmodule

// File: tb/tb_backscatter_modulator.sv
// Self-checking bench for backscatter_modulator (HALF_PERIOD=2,
// SYMBOL_CYCLES=8, CNT_W=3 so saturation is reachable).
module tb_backscatter_modulator;

    localparam int HP    = 2;
    localparam int SC    = 8;
    localparam int CW    = 3;
    localparam int TMAX  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          sending = 1'b0;
    logic          data_in = 1'b0;
    logic          rf_ctrl;
    logic          busy;
    logic          bit_tick;
    logic [CW-1:0] symbol_total;

    int n_checks = 0;
    int n_fail   = 0;

    backscatter_modulator #(
        .HALF_PERIOD(HP),
        .SYMBOL_CYCLES(SC),
        .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sending(sending),
        .data_in(data_in),
        .rf_ctrl(rf_ctrl),
        .busy(busy),
        .bit_tick(bit_tick),
        .symbol_total(symbol_total)
    );

    always #5 clock = ~clock;

    // Behavioural reference: a burst is a run of whole symbols counted from
    // its start edge; it continues past a boundary exactly when sending is
    // high at that boundary edge. Waveform is pure arithmetic on the offset.
    int   m_edge   = 0;
    bit   m_active = 0;
    int   m_start  = 0;
    bit   m_phase  = 0;
    bit   m_prev_s = 0;
    bit   m_tick_q = 0;
    int   m_total  = 0;
    bit   m_rf, m_busy, m_tick;
    bit   chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit d);
        int off;
        m_edge++;
        if (r) begin
            m_active = 0;
            m_prev_s = 0;
            m_total  = 0;
        end else begin
            if (m_tick_q && m_total < TMAX) m_total++;
            if (m_active && ((m_edge - m_start) % SC == 0)) begin
                if (s) begin
`ifdef MOD_DIFF_EN
                    m_phase = m_phase ^ d;
`else
                    m_phase = d;
`endif
                end else begin
                    m_active = 0;
                end
            end else if (!m_active && s && !m_prev_s) begin
                m_active = 1;
                m_start  = m_edge;
                m_phase  = d;
            end
            m_prev_s = s;
        end
        off      = m_edge - m_start;
        m_busy   = m_active;
        m_tick   = m_active && (off % SC == 0);
        m_rf     = m_active && ((((off / HP) % 2) == 1) ^ m_phase);
        m_tick_q = m_tick;
    endtask

    // One clock: drive inputs, advance the model at the edge, sample at +1
    task automatic step(input bit r, input bit s, input bit d);
        reset   = r;
        sending = s;
        data_in = d;
        @(posedge clock);
        model_edge(r, s, d);
        #1;
        if (chk_en) begin
            check("rand_rf_ctrl", rf_ctrl, m_rf);
            check("rand_busy", busy, m_busy);
            check("rand_bit_tick", bit_tick, m_tick);
            check("rand_symbol_total", symbol_total, m_total);
        end
    endtask

    typedef struct {
        bit rst, snd, din;
        bit exp_rf, exp_busy, exp_tick;
    } vec_t;

    vec_t     tbl[26];
    bit       bits[3];
    bit [7:0] sym_rf[3];

    initial begin
        int ticks, busy_cyc;

        // ---- reset held 3 cycles with sending high ----
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1);
            check("reset_rf_ctrl", rf_ctrl, 0);
            check("reset_busy", busy, 0);
            check("reset_bit_tick", bit_tick, 0);
            check("reset_symbol_total", symbol_total, 0);
        end
        step(0, 0, 0);
        step(0, 0, 0);

        // ---- table: 3 symbols then sending drops at the boundary ----
`ifdef MOD_DIFF_EN
        bits   = '{1'b1, 1'b1, 1'b0};
        sym_rf = '{8'b1100_1100, 8'b0011_0011, 8'b0011_0011};
`else
        bits   = '{1'b1, 1'b0, 1'b1};
        sym_rf = '{8'b1100_1100, 8'b0011_0011, 8'b1100_1100};
`endif
        for (int i = 0; i < 26; i++) begin
            tbl[i].rst = 0;
            tbl[i].snd = (i < 24);
            // Off-boundary data is the inverse bit: it must not be sampled
            tbl[i].din = (i < 24) ? ((i % 8 == 0) ? bits[i/8] : ~bits[i/8]) : 1'b0;
            tbl[i].exp_busy = (i < 24);
            tbl[i].exp_tick = (i < 24) && (i % 8 == 0);
            tbl[i].exp_rf   = (i < 24) ? sym_rf[i/8][7 - (i % 8)] : 1'b0;
        end
        for (int i = 0; i < 26; i++) begin
            step(tbl[i].rst, tbl[i].snd, tbl[i].din);
            check($sformatf("tbl_rf_ctrl[%0d]", i), rf_ctrl, tbl[i].exp_rf);
            check($sformatf("tbl_busy[%0d]", i), busy, tbl[i].exp_busy);
            check($sformatf("tbl_bit_tick[%0d]", i), bit_tick, tbl[i].exp_tick);
        end
        check("tbl_symbol_total", symbol_total, 3);

        // ---- sending drops at cycle 3 of symbol 1: drain to the boundary ----
        step(1, 0, 0);
        step(0, 0, 0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, i < 11, 1);
            ticks += int'(bit_tick);
            if (i == 8)  check("drain_tick_sym1", bit_tick, 1);
            if (i == 15) check("drain_busy_last", busy, 1);
            if (i == 16) begin
                check("drain_busy_end", busy, 0);
                check("drain_rf_end", rf_ctrl, 0);
            end
        end
        check("drain_tick_count", ticks, 2);
        check("drain_symbol_total", symbol_total, 2);

        // ---- one-cycle dropout mid-symbol: no gap ----
        step(1, 0, 0);
        step(0, 0, 0);
        busy_cyc = 0;
        ticks    = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, i != 4, 0);
            busy_cyc += int'(busy);
            ticks    += int'(bit_tick);
            if (i == 8) check("glitch_tick_next", bit_tick, 1);
            if (i == 9) check("glitch_rf_sym1", rf_ctrl, 0);
        end
        check("glitch_busy_cycles", busy_cyc, 24);
        check("glitch_tick_count", ticks, 3);
        step(0, 0, 0);
        check("glitch_end_busy", busy, 0);

        // ---- reset at cycle 5 of a burst, then restart ----
        step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1);
        step(1, 1, 1);
        check("midrst_rf_ctrl", rf_ctrl, 0);
        check("midrst_busy", busy, 0);
        check("midrst_symbol_total", symbol_total, 0);
        step(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1);
            if (i == 0) begin
                check("restart_tick", bit_tick, 1);
                check("restart_rf", rf_ctrl, 1);
            end
            if (i == 7) begin
                check("restart_tick_off", bit_tick, 0);
                check("restart_total", symbol_total, 1);
            end
            if (i == 8) check("restart_tick_sym1", bit_tick, 1);
        end
        step(0, 0, 0);

        // ---- saturation: 9 symbols with a 3-bit counter ----
        step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 9 * SC; i++) step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("sat_symbol_total", symbol_total, TMAX);

        // ---- randomized traffic against the reference model ----
        step(1, 0, 0);
        chk_en = 1;
        begin
            bit s;
            s = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(11) == 0) s = ~s;
                step(($urandom_range(499) == 0), s, 1'($urandom_range(1)));
            end
        end
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
